// File: rtl/rom_loader.sv
// Splits 16-bit HPS ioctl download words into byte writes for four ROM regions,
// with backpressure, a running checksum, sticky error flags and a done pulse.
module rom_loader #(
  parameter int unsigned ADDR_W    = 17,
  parameter logic [26:0] REG1_BASE = 27'h10000,
  parameter logic [26:0] REG2_BASE = 27'h18000,
  parameter logic [26:0] REG3_BASE = 27'h28000,
  parameter logic [26:0] IMG_SIZE  = 27'h48000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic              ioctl_wait,
  output logic [3:0]        rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  input  logic              rom_ready,
  output logic [15:0]       checksum,
  output logic              overflow,
  output logic              proto_err,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, FLUSH} state_t;

  state_t      state;
  logic [26:0] hi_addr_q;
  logic [7:0]  hi_data_q;
  logic        dl_q;
  logic        clr_pend;
  logic        byte_ovf;

  logic [26:0] sel_addr;
  logic [26:0] sel_base;
  logic [7:0]  sel_data;
  logic [3:0]  sel_we;
  logic        sel_ovf;
  logic        dl_rise;
  logic        dl_fall;
  logic        clear_now;

  assign ioctl_wait = ioctl_wr | (state != IDLE);
  assign dl_rise    = ioctl_download & ~dl_q;
  assign dl_fall    = ~ioctl_download & dl_q;
  // A start seen mid-word is deferred until the word has drained.
  assign clear_now  = (state == IDLE) && (dl_rise || clr_pend);

  // Decode the byte that will be presented next: the low byte straight off the
  // bus when idle, otherwise the latched high byte.
  always_comb begin
    sel_addr = (state == IDLE) ? ioctl_addr : hi_addr_q;
    sel_data = (state == IDLE) ? ioctl_dout[7:0] : hi_data_q;
    sel_we   = '0;
    sel_base = '0;
    sel_ovf  = 1'b0;
    if (sel_addr >= IMG_SIZE) begin
      sel_ovf = 1'b1;
    end else if (sel_addr >= REG3_BASE) begin
      sel_we   = 4'b1000;
      sel_base = REG3_BASE;
    end else if (sel_addr >= REG2_BASE) begin
      sel_we   = 4'b0100;
      sel_base = REG2_BASE;
    end else if (sel_addr >= REG1_BASE) begin
      sel_we   = 4'b0010;
      sel_base = REG1_BASE;
    end else begin
      sel_we = 4'b0001;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hi_addr_q <= '0;
      hi_data_q <= '0;
      dl_q      <= 1'b0;
      clr_pend  <= 1'b0;
      byte_ovf  <= 1'b0;
      rom_we    <= '0;
      rom_addr  <= '0;
      rom_data  <= '0;
      checksum  <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      done <= 1'b0;
      if (dl_rise && state != IDLE) clr_pend <= 1'b1;
      if (clear_now) begin
        checksum  <= '0;
        overflow  <= 1'b0;
        proto_err <= 1'b0;
        clr_pend  <= 1'b0;
      end
      if (ioctl_wr && state != IDLE) proto_err <= 1'b1;

      case (state)
        IDLE: begin
          if (ioctl_wr && ioctl_download) begin
            hi_addr_q <= {ioctl_addr[26:1], 1'b1};
            hi_data_q <= ioctl_dout[15:8];
            rom_we    <= sel_we;
            rom_addr  <= ADDR_W'(sel_addr - sel_base);
            rom_data  <= sel_data;
            byte_ovf  <= sel_ovf;
            state     <= WR_LO;
          end else if (dl_fall) begin
            done  <= 1'b1;
            state <= FLUSH;
          end
        end
        WR_LO: begin
          if (byte_ovf || rom_ready) begin
            if (byte_ovf) overflow <= 1'b1;
            else          checksum <= checksum + 16'(rom_data);
            rom_we   <= sel_we;
            rom_addr <= ADDR_W'(sel_addr - sel_base);
            rom_data <= sel_data;
            byte_ovf <= sel_ovf;
            state    <= WR_HI;
          end
        end
        WR_HI: begin
          if (byte_ovf || rom_ready) begin
            if (byte_ovf) overflow <= 1'b1;
            else          checksum <= checksum + 16'(rom_data);
            rom_we   <= '0;
            byte_ovf <= 1'b0;
            done     <= ~ioctl_download;
            state    <= ioctl_download ? IDLE : FLUSH;
          end
        end
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: directed vector table, multi-cycle corner sequences and
// randomized words checked against a byte-level write/checksum model.
module tb_rom_loader;

  localparam int unsigned IMG = 'h48000;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_wait;
  logic [3:0]  rom_we;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ready = 1'b1;
  logic [15:0] checksum;
  logic        overflow;
  logic        proto_err;
  logic        done;

  rom_loader #(.ADDR_W(17)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ready(rom_ready), .checksum(checksum),
    .overflow(overflow), .proto_err(proto_err), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct {logic [3:0] we; logic [16:0] la; logic [7:0] data;} wr_t;
  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [15:0] model_sum = '0;
  bit          model_ovf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  // Image byte address -> region strobe and local address; 0 when discarded.
  function automatic bit model_byte(input int unsigned a, output logic [3:0] we,
                                    output logic [16:0] la);
    int unsigned bases[4];
    bases = '{0, 'h10000, 'h18000, 'h28000};
    we = '0;
    la = '0;
    if (a >= IMG) return 1'b0;
    for (int r = 3; r >= 0; r--) begin
      if (a >= bases[r]) begin
        we = 4'(1 << r);
        la = 17'(a - bases[r]);
        break;
      end
    end
    return 1'b1;
  endfunction

  task automatic push_word(input logic [26:0] a, input logic [15:0] d);
    wr_t e;
    logic [7:0] b;
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? d[7:0] : d[15:8];
      if (model_byte({5'd0, a} + 32'(k), e.we, e.la)) begin
        e.data = b;
        exp_q.push_back(e);
        model_sum = model_sum + 16'(b);
      end else begin
        model_ovf = 1'b1;
      end
    end
  endtask

  // Every accepted ROM write must be the next one the model predicts.
  always @(negedge clk_sys) begin
    if (done) done_cnt++;
    if (reset_n && rom_we != 4'b0000 && rom_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_write", {rom_we, rom_addr, rom_data}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("write", {rom_we, rom_addr, rom_data}, {mon_e.we, mon_e.la, mon_e.data});
      end
    end
  end

  task automatic send_word(input logic [26:0] a, input logic [15:0] d, input bit rnd);
    int n;
    tick;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (!rnd) rom_ready = 1'b1;
    push_word(a, d);
    tick;
    ioctl_wr = 1'b0;
    n = 0;
    while (ioctl_wait && n < 200) begin
      rom_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL wait_bound: ioctl_wait still high after %0d cycles, required low", n);
    end
  endtask

  task automatic start_download;
    tick;
    ioctl_download = 1'b1;
    model_sum = '0;
    model_ovf = 1'b0;
    tick;
    tick;
    @(negedge clk_sys);
    check("start_clear", {checksum, overflow, proto_err}, 0);
  endtask

  task automatic end_download;
    int n0;
    tick;
    ioctl_download = 1'b0;
    n0 = done_cnt;
    repeat (4) tick;
    check("done_once", done_cnt - n0, 1);
  endtask

  typedef struct {logic [26:0] addr; logic [15:0] dout; logic [3:0] we; logic [16:0] la;} vec_t;
  vec_t vecs[9];

  initial begin
    logic [26:0] a;
    logic [15:0] ref_sum;
    int unsigned sel;
    int unsigned edges[4];
    int n0;

    vecs[0] = '{27'h00000, 16'hBEEF, 4'b0001, 17'h00000};
    vecs[1] = '{27'h0FFFE, 16'h1122, 4'b0001, 17'h0FFFE};
    vecs[2] = '{27'h10000, 16'h3344, 4'b0010, 17'h00000};
    vecs[3] = '{27'h17FFE, 16'h5566, 4'b0010, 17'h07FFE};
    vecs[4] = '{27'h18000, 16'h7788, 4'b0100, 17'h00000};
    vecs[5] = '{27'h27FFE, 16'h99AA, 4'b0100, 17'h0FFFE};
    vecs[6] = '{27'h28000, 16'hBBCC, 4'b1000, 17'h00000};
    vecs[7] = '{27'h47FFE, 16'hDDEE, 4'b1000, 17'h1FFFE};
    vecs[8] = '{27'h48000, 16'hF00D, 4'b0000, 17'h00000};
    edges   = '{'h10000, 'h18000, 'h28000, 'h48000};

    @(negedge clk_sys);
    check("reset_state", {ioctl_wait, rom_we, rom_addr, rom_data, checksum, overflow, proto_err, done}, 0);
    tick;
    reset_n = 1'b1;
    start_download;

    for (int i = 0; i < 9; i++) begin
      tick;
      ioctl_addr = vecs[i].addr;
      ioctl_dout = vecs[i].dout;
      ioctl_wr   = 1'b1;
      push_word(vecs[i].addr, vecs[i].dout);
      @(negedge clk_sys);
      check("t_wait_c0", ioctl_wait, 1);
      tick;
      ioctl_wr = 1'b0;
      @(negedge clk_sys);
      check("t_we_lo", rom_we, vecs[i].we);
      check("t_wait_c1", ioctl_wait, 1);
      if (vecs[i].we != 4'b0000)
        check("t_lo", {rom_addr, rom_data}, {vecs[i].la, vecs[i].dout[7:0]});
      tick;
      @(negedge clk_sys);
      check("t_we_hi", rom_we, vecs[i].we);
      check("t_wait_c2", ioctl_wait, 1);
      if (vecs[i].we != 4'b0000)
        check("t_hi", {rom_addr, rom_data}, {vecs[i].la + 17'd1, vecs[i].dout[15:8]});
      tick;
      @(negedge clk_sys);
      check("t_idle", {ioctl_wait, rom_we}, 0);
      check("t_sum", checksum, model_sum);
      check("t_ovf", overflow, model_ovf);
      if (i == 0) check("t_sum_beef", checksum, 16'h01AD);
    end
    check("ovf_set", overflow, 1);

    end_download;
    start_download;

    // Backpressure: sink stalls the low byte for five cycles.
    tick;
    rom_ready  = 1'b0;
    ioctl_addr = 27'h100;
    ioctl_dout = 16'h1234;
    ioctl_wr   = 1'b1;
    push_word(27'h100, 16'h1234);
    tick;
    ioctl_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      check("bp_hold", {rom_we, rom_addr, rom_data, ioctl_wait}, {4'b0001, 17'h100, 8'h34, 1'b1});
      tick;
    end
    rom_ready = 1'b1;
    repeat (3) tick;
    @(negedge clk_sys);
    check("bp_sum", checksum, model_sum);

    // Busy strobe during WR_LO, then download end during WR_HI.
    tick;
    rom_ready  = 1'b0;
    ioctl_addr = 27'h200;
    ioctl_dout = 16'h5566;
    ioctl_wr   = 1'b1;
    push_word(27'h200, 16'h5566);
    n0 = done_cnt;
    tick;
    ioctl_addr = 27'h300;
    ioctl_dout = 16'h7788;
    tick;
    ioctl_wr  = 1'b0;
    rom_ready = 1'b1;
    @(negedge clk_sys);
    check("proto_err", proto_err, 1);
    tick;
    ioctl_download = 1'b0;
    repeat (4) tick;
    check("proto_done_once", done_cnt - n0, 1);
    check("proto_sum", checksum, model_sum);
    start_download;

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 5);
      if (sel < 4) a = 27'(edges[sel] - 8 + 2 * $urandom_range(0, 7));
      else         a = 27'(2 * $urandom_range(0, (IMG + 'h40) / 2 - 1));
      send_word(a, 16'($urandom), 1'b1);
    end
    @(negedge clk_sys);
    check("rand_sum", checksum, model_sum);
    check("rand_ovf", overflow, model_ovf);
    check("rand_proto", proto_err, 0);
    end_download;

    // Contiguous incrementing-byte image over the top of the map.
    start_download;
    ref_sum = '0;
    for (int unsigned b = 'h44000; b < IMG; b++) ref_sum = ref_sum + 16'(b & 'hFF);
    for (int unsigned b = 'h44000; b < IMG; b += 2) send_word(27'(b), {8'(b + 1), 8'(b)}, 1'b0);
    @(negedge clk_sys);
    check("img_sum", checksum, ref_sum);
    check("img_ovf", overflow, 0);
    end_download;
    check("img_proto", proto_err, 0);

    // Reset asserted while a low byte is being presented.
    start_download;
    send_word(27'h20, 16'h0102, 1'b0);
    tick;
    rom_ready  = 1'b0;
    ioctl_addr = 27'h40;
    ioctl_dout = 16'hAA55;
    ioctl_wr   = 1'b1;
    tick;
    ioctl_wr = 1'b0;
    check("pre_reset", {rom_we, checksum}, {4'b0001, 16'h0003});
    #1 reset_n = 1'b0;
    #1 check("reset_async", {ioctl_wait, rom_we, rom_addr, rom_data, checksum, overflow, proto_err, done}, 0);
    tick;
    reset_n = 1'b1;
    tick;
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Sits between the HPS ioctl download stream and the game core's ROM memories, upstream of the core's ROM write ports.
- Accepts 16-bit ioctl words and splits each into two byte writes.
- Decodes the ROM image address into one of four regions (CPU, sound, tiles, sprites) and throttles the HPS with ioctl_wait while the bytes are written.
- Keeps a running byte checksum, flags overflow and protocol errors, and pulses done when a download completes.

Parameters:
- ADDR_W, 17, width of the region-local ROM byte address.
- REG1_BASE, 27'h10000, first image byte address of region 1.
- REG2_BASE, 27'h18000, first image byte address of region 2.
- REG3_BASE, 27'h28000, first image byte address of region 3.
- IMG_SIZE, 27'h48000, total image bytes; writes at or beyond this are discarded.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ioctl_download  in  1  download active, already qualified to index 0
- ioctl_wr  in  1  single-cycle word strobe
- ioctl_addr  in  27  image byte address, always even
- ioctl_dout  in  16  data word; [7:0] goes to addr, [15:8] to addr+1
- ioctl_wait  out  1  backpressure to the HPS
- rom_we  out  4  one-hot byte write strobe, one bit per region
- rom_addr  out  ADDR_W  region-local byte address
- rom_data  out  8  byte data
- rom_ready  in  1  sink accepts the presented write in the current cycle
- checksum  out  16  modulo-2^16 sum of all accepted bytes in this download
- overflow  out  1  sticky: a byte was addressed at or beyond IMG_SIZE
- proto_err  out  1  sticky: ioctl_wr arrived while busy
- done  out  1  one-cycle pulse when the download ends and all writes have drained

Behaviour:
- Reset (async assert, synchronous release): state IDLE; all outputs 0; internal word latch cleared.
- Region decode of byte address A:
  - region 3 if A >= REG3_BASE; else region 2 if A >= REG2_BASE; else region 1 if A >= REG1_BASE; else region 0.
  - Local address = A minus the region base, truncated to ADDR_W.
  - Decode is done per byte, so a word straddling a base splits across two regions.
- States: IDLE, WR_LO, WR_HI, FLUSH.
- IDLE:
  - On ioctl_wr with ioctl_download=1, latch addr and data and go to WR_LO the next cycle.
  - ioctl_wr while ioctl_download=0 is ignored.
- WR_LO:
  - Present low byte at A with the rom_we bit set.
  - Hold all outputs stable until rom_ready=1 in the same cycle, then go to WR_HI.
- WR_HI: same as WR_LO for the high byte at A+1; on acceptance go to IDLE, or to FLUSH if ioctl_download is already 0.
- FLUSH: assert done for exactly one cycle, then go to IDLE.
- Bytes with A >= IMG_SIZE:
  - rom_we stays 0; the state advances without waiting for rom_ready.
  - overflow is set and the checksum is not updated.
- Checksum: adds each accepted byte (rom_we & rom_ready) zero-extended; wraps mod 2^16.
- ioctl_wait = ioctl_wr | (state != IDLE), combinational, so it rises in the same cycle as the strobe.
- Busy strobe: ioctl_wr while state != IDLE sets proto_err; the word is dropped and the current write is unaffected.
- Download start (ioctl_download 0->1): clear checksum, overflow and proto_err. If the download was interrupted mid-word, finish that word first, then clear.
- Download end (ioctl_download 1->0):
  - In IDLE, done pulses on the following cycle via FLUSH.
  - Mid-word, the word completes and then FLUSH runs.
- Minimum write latency: strobe at cycle 0, low byte rom_we at cycle 1, high byte at cycle 2 (rom_ready tied high). ioctl_wait is high for cycles 0-2.
- Reset mid-operation aborts the write immediately; no partial-word recovery.

Test Plan:
- Basic word write: rom_ready=1, addr 0x0000, dout 0xBEEF. Required: cycle1 rom_we=0001 rom_addr=0 data=EF; cycle2 rom_addr=1 data=BE; ioctl_wait high cycles 0-2; checksum=0x01AD.
- Region straddle: write at REG1_BASE-2 (0xFFFE) then at 0x10000. Required: region0 addrs 0xFFFE/0xFFFF, then rom_we=0010 at local addrs 0/1. Repeat at the REG2 and REG3 bases.
- Backpressure: rom_ready low for 5 cycles during WR_LO. Required: rom_addr, rom_data and rom_we stable for those 5 cycles; ioctl_wait high throughout; the byte is counted once in checksum.
- Overflow: write at IMG_SIZE-1... use 0x47FFE, then at 0x48000. Required: first word written normally; second produces no rom_we, overflow=1, checksum unchanged; the next download start clears overflow.
- Protocol error and end: issue ioctl_wr during WR_LO, then drop ioctl_download during WR_HI. Required: proto_err=1, the extra word is not written, done pulses exactly once after the high byte is accepted.
- Full image: stream 0x48000 incrementing bytes. Required: checksum equals the reference sum mod 2^16, exactly one done pulse, no proto_err. Then assert reset_n=0 mid-word: all outputs go to 0 asynchronously.
